// File: rtl/drw_cmdfetch.sv
// Draw command fetcher: pops header/parameter words from the command FIFO, decodes them and
// issues complete commands to the draw engine. Optional param watchdog: `define DRW_TIMEOUT_EN.
module drw_cmdfetch #(
  parameter int unsigned TIMEOUT_W   = 16,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic        CLK,
  input  logic        ARST,
  input  logic        SOFT_RST,
  input  logic        DRW_START,
  output logic        DRW_BUSY,
  output logic        DRW_IRQ_IN,
  output logic [2:0]  ERR,
  input  logic        FIFO_EMPTY,
  output logic        FIFO_RD,
  input  logic [31:0] FIFO_RDATA,
  output logic        CMD_VALID,
  input  logic        CMD_READY,
  output logic [3:0]  CMD_OP,
  output logic [31:0] CMD_P0,
  output logic [31:0] CMD_P1,
  input  logic        ENG_BUSY
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StWait   = 3'd2;
  localparam logic [2:0] StDecode = 3'd3;
  localparam logic [2:0] StIssue  = 3'd4;
  localparam logic [2:0] StFinish = 3'd5;

  localparam logic [7:0] OpNop      = 8'h00;
  localparam logic [7:0] OpSetFrame = 8'h01;
  localparam logic [7:0] OpSetColor = 8'h02;
  localparam logic [7:0] OpPatBlt   = 8'h03;
  localparam logic [7:0] OpEodl     = 8'h0F;

  function automatic logic [1:0] param_cnt(input logic [7:0] op);
    logic [1:0] n;
    case (op)
      OpSetFrame, OpPatBlt: n = 2'd2;
      OpSetColor:           n = 2'd1;
      default:              n = 2'd0;
    endcase
    return n;
  endfunction

  logic [2:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;      // 0 = header, 1/2 = parameter word
  logic [7:0]  hdr_q, hdr_d;
  logic [31:0] p0_q, p0_d;
  logic [31:0] p1_q, p1_d;
  logic        valid_q, valid_d;
  logic        irq_q, irq_d;
  logic [2:0]  err_q, err_d;

`ifdef DRW_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] ToLast = TIMEOUT_W'(TIMEOUT_CYC - 1);
  logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_W, TIMEOUT_CYC};
`endif

  assign FIFO_RD    = (state_q == StFetch) & ~FIFO_EMPTY;
  assign DRW_BUSY   = (state_q != StIdle);
  assign DRW_IRQ_IN = irq_q;
  assign ERR        = err_q;
  assign CMD_VALID  = valid_q;
  assign CMD_OP     = hdr_q[3:0];
  assign CMD_P0     = p0_q;
  assign CMD_P1     = p1_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hdr_d   = hdr_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    valid_d = valid_q;
    irq_d   = 1'b0;
    err_d   = err_q;
`ifdef DRW_TIMEOUT_EN
    to_cnt_d = '0;
`endif

    case (state_q)
      StIdle: begin
        if (DRW_START) begin
          state_d = StFetch;
          idx_d   = 2'd0;
          err_d   = 3'd0;
        end
      end
      StFetch: begin
        if (FIFO_RD) begin
          state_d = StWait;
        end
`ifdef DRW_TIMEOUT_EN
        // Only a partially received command can time out; header waits are unbounded.
        else if (idx_q != 2'd0) begin
          if (to_cnt_q == ToLast) begin
            err_d   = 3'd2;
            irq_d   = 1'b1;
            state_d = StIdle;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
`endif
      end
      StWait: begin
        if (idx_q == 2'd0) begin
          hdr_d = FIFO_RDATA[31:24];
          p0_d  = '0;
          p1_d  = '0;
          if (param_cnt(FIFO_RDATA[31:24]) != 2'd0) begin
            idx_d   = 2'd1;
            state_d = StFetch;
          end else begin
            state_d = StDecode;
          end
        end else begin
          if (idx_q == 2'd1) p0_d = FIFO_RDATA;
          else               p1_d = FIFO_RDATA;
          if (idx_q < param_cnt(hdr_q)) begin
            idx_d   = idx_q + 2'd1;
            state_d = StFetch;
          end else begin
            state_d = StDecode;
          end
        end
      end
      StDecode: begin
        idx_d = 2'd0;
        case (hdr_q)
          OpNop:  state_d = StFetch;
          OpEodl: state_d = StFinish;
          OpSetFrame, OpSetColor, OpPatBlt: begin
            valid_d = 1'b1;
            state_d = StIssue;
          end
          default: begin
            err_d   = 3'd1;
            irq_d   = 1'b1;
            state_d = StIdle;
          end
        endcase
      end
      StIssue: begin
        if (CMD_READY) begin
          valid_d = 1'b0;
          state_d = StFetch;
        end
      end
      StFinish: begin
        if (!ENG_BUSY) begin
          irq_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Soft reset wins over everything, including a same-cycle START.
    if (SOFT_RST) begin
      state_d = StIdle;
      idx_d   = 2'd0;
      hdr_d   = '0;
      p0_d    = '0;
      p1_d    = '0;
      valid_d = 1'b0;
      irq_d   = 1'b0;
      err_d   = 3'd0;
`ifdef DRW_TIMEOUT_EN
      to_cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      hdr_q   <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
      valid_q <= 1'b0;
      irq_q   <= 1'b0;
      err_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hdr_q   <= hdr_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      valid_q <= valid_d;
      irq_q   <= irq_d;
      err_q   <= err_d;
    end
  end

`ifdef DRW_TIMEOUT_EN
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) to_cnt_q <= '0;
    else      to_cnt_q <= to_cnt_d;
  end
`endif

endmodule
